toy_mem_responder: RTL and testbench

- Memory-side responder for the RISC_TOY core's instruction port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA).
- Serves a unified word-addressed RAM with one-cycle registered read latency.
- Adds a small MMIO window: free-running cycle counter, byte console FIFO with external drain handshake, and a sticky HALT register for testbench end-of-run.
- Includes a loader port that writes the program image into RAM before or while the core is held in reset.

---
 rtl/toy_mem_pkg.sv | 29 ++
 rtl/toy_con_fifo.sv | 60 ++++++
 rtl/toy_mem_responder.sv | 138 +++++++++++++
 tb/tb_toy_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_mem_pkg.sv
// Shared constants for the RISC_TOY memory responder: MMIO decode, DRW encoding
// and console status bit layout.
package toy_mem_pkg;

    localparam int MMIO_SEL_BIT = 29;

    localparam logic DRW_WRITE = 1'b1;
    localparam logic DRW_READ  = 1'b0;

    localparam logic [3:0] OFS_CYCLE = 4'd0;
    localparam logic [3:0] OFS_CON   = 4'd1;
    localparam logic [3:0] OFS_HALT  = 4'd2;

    localparam int CON_EMPTY_BIT = 0;
    localparam int CON_FULL_BIT  = 1;
    localparam int CON_OVF_BIT   = 2;

    // Packs the console status word returned by a read of the CON register.
    function automatic logic [31:0] con_status(input logic ovf, input logic full,
                                               input logic empty);
        logic [31:0] s;
        s                = '0;
        s[CON_EMPTY_BIT] = empty;
        s[CON_FULL_BIT]  = full;
        s[CON_OVF_BIT]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/toy_con_fifo.sv
// Byte-wide synchronous console FIFO with a sticky overflow flag.
// A push while full is accepted only if a pop frees a slot on the same edge.
module toy_con_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            if (push & ~do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/toy_mem_responder.sv
// Memory-side responder for the RISC_TOY core: unified word RAM behind the fetch and
// data ports, an MMIO window (cycle counter, console FIFO, HALT) and a loader port.
module toy_mem_responder
    import toy_mem_pkg::*;
#(
    parameter int AW         = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IREQ,
    input  logic [29:0]   IADDR,
    output logic [31:0]   INSTR,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    input  logic          LD_WE,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [31:0]   LD_DATA,
    output logic          CON_VALID,
    output logic [7:0]    CON_DATA,
    input  logic          CON_READY,
    output logic          HALT,
    output logic [31:0]   HALT_CODE
);

    // Console handshake: a byte moves on every rising edge where CON_VALID and
    // CON_READY are both high; CON_DATA holds the head byte steady until then.

    logic [31:0] ram [0:(1<<AW)-1];

    logic        i_mmio;
    logic        d_mmio;
    logic [3:0]  ofs;
    logic        d_rd;
    logic        d_wr;
    logic        ram_wr;
    logic        mmio_wr;
    logic        cyc_wr;
    logic        con_wr;
    logic        halt_wr;
    logic [31:0] cycle_q;
    logic [31:0] mmio_rdata;
    logic        con_full;
    logic        con_empty;
    logic        con_ovf;
    logic        unused_addr_bits;

    assign i_mmio  = IADDR[MMIO_SEL_BIT];
    assign d_mmio  = DADDR[MMIO_SEL_BIT];
    assign ofs     = DADDR[3:0];
    assign d_rd    = DREQ & (DRW == DRW_READ);
    assign d_wr    = DREQ & (DRW == DRW_WRITE);

    // The loader owns the RAM write port whenever it is active, reset or not.
    assign ram_wr  = d_wr & ~d_mmio & ~LD_WE & ~RST;
    assign mmio_wr = d_wr & d_mmio & ~RST;
    assign cyc_wr  = mmio_wr & (ofs == OFS_CYCLE);
    assign con_wr  = mmio_wr & (ofs == OFS_CON);
    assign halt_wr = mmio_wr & (ofs == OFS_HALT);

    // Upper RAM-region address bits alias by design.
    assign unused_addr_bits = ^{IADDR[28:AW], DADDR[28:AW]};

    always_ff @(posedge CLK) begin
        if (LD_WE) begin
            ram[LD_ADDR] <= LD_DATA;
        end else if (ram_wr) begin
            ram[DADDR[AW-1:0]] <= DWDATA;
        end
    end

    // Nonblocking reads of ram give read-before-write on same-word collisions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            INSTR <= '0;
        end else if (IREQ) begin
            INSTR <= i_mmio ? 32'h0 : ram[IADDR[AW-1:0]];
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (ofs)
            OFS_CYCLE: mmio_rdata = cycle_q;
            OFS_CON:   mmio_rdata = con_status(con_ovf, con_full, con_empty);
            OFS_HALT:  mmio_rdata = HALT_CODE;
            default:   mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DRDATA <= '0;
        end else if (d_rd) begin
            DRDATA <= d_mmio ? mmio_rdata : ram[DADDR[AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_q <= '0;
        end else if (cyc_wr) begin
            cycle_q <= DWDATA;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HALT      <= 1'b0;
            HALT_CODE <= '0;
        end else if (halt_wr) begin
            HALT      <= 1'b1;
            HALT_CODE <= DWDATA;
        end
    end

    toy_con_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (con_wr),
        .push_data (DWDATA[7:0]),
        .pop       (CON_READY),
        .head_data (CON_DATA),
        .full      (con_full),
        .empty     (con_empty),
        .overflow  (con_ovf)
    );

    assign CON_VALID = ~con_empty;

endmodule

// File: tb/tb_toy_mem_responder.sv
// Self-checking bench for toy_mem_responder: directed scenarios followed by random
// traffic, all checked against a behavioural model (RAM array, byte queue, counters).
module tb_toy_mem_responder;

    localparam int AW = 12;
    localparam int FD = 8;
    localparam logic [29:0] A_CYCLE = 30'h2000_0000;
    localparam logic [29:0] A_CON   = 30'h2000_0001;
    localparam logic [29:0] A_HALT  = 30'h2000_0002;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IREQ;
    logic [29:0]   IADDR;
    logic [31:0]   INSTR;
    logic          DREQ;
    logic          DRW;
    logic [29:0]   DADDR;
    logic [31:0]   DWDATA;
    logic [31:0]   DRDATA;
    logic          LD_WE;
    logic [AW-1:0] LD_ADDR;
    logic [31:0]   LD_DATA;
    logic          CON_VALID;
    logic [7:0]    CON_DATA;
    logic          CON_READY;
    logic          HALT;
    logic [31:0]   HALT_CODE;

    int n_vec = 0;
    int n_mis = 0;

    // behavioural model state
    logic [31:0] m_mem [0:(1<<AW)-1];
    logic [7:0]  m_q[$];
    logic [31:0] m_cnt, m_code, m_instr, m_drdata;
    logic        m_ovf, m_halt;

    toy_mem_responder #(.AW(AW), .FIFO_DEPTH(FD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IREQ      (IREQ),
        .IADDR     (IADDR),
        .INSTR     (INSTR),
        .DREQ      (DREQ),
        .DRW       (DRW),
        .DADDR     (DADDR),
        .DWDATA    (DWDATA),
        .DRDATA    (DRDATA),
        .LD_WE     (LD_WE),
        .LD_ADDR   (LD_ADDR),
        .LD_DATA   (LD_DATA),
        .CON_VALID (CON_VALID),
        .CON_DATA  (CON_DATA),
        .CON_READY (CON_READY),
        .HALT      (HALT),
        .HALT_CODE (HALT_CODE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT, compare.
    task automatic step();
        logic [31:0] nx_instr, nx_dr, mrd;
        logic        pop, was_full;
        int          sz;
        if (RST) begin
            if (LD_WE) m_mem[LD_ADDR] = LD_DATA;
            m_instr = 0; m_drdata = 0; m_cnt = 0; m_halt = 0; m_code = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            sz = m_q.size();
            nx_instr = m_instr;
            if (IREQ) nx_instr = IADDR[29] ? 32'h0 : m_mem[IADDR[AW-1:0]];
            case (DADDR[3:0])
                4'd0:    mrd = m_cnt;
                4'd1:    mrd = {29'b0, m_ovf, sz == FD, sz == 0};
                4'd2:    mrd = m_code;
                default: mrd = 32'h0;
            endcase
            nx_dr = m_drdata;
            if (DREQ && !DRW) nx_dr = DADDR[29] ? mrd : m_mem[DADDR[AW-1:0]];
            pop = CON_READY && sz > 0;
            was_full = (sz == FD);
            if (DREQ && DRW && DADDR[29] && DADDR[3:0] == 4'd0) m_cnt = DWDATA;
            else m_cnt = m_cnt + 1;
            if (pop) void'(m_q.pop_front());
            if (DREQ && DRW && DADDR[29] && DADDR[3:0] == 4'd1) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else m_q.push_back(DWDATA[7:0]);
            end
            if (DREQ && DRW && DADDR[29] && DADDR[3:0] == 4'd2) begin
                m_halt = 1'b1;
                m_code = DWDATA;
            end
            if (LD_WE) m_mem[LD_ADDR] = LD_DATA;
            else if (DREQ && DRW && !DADDR[29]) m_mem[DADDR[AW-1:0]] = DWDATA;
            m_instr = nx_instr;
            m_drdata = nx_dr;
        end
        @(posedge CLK);
        #1;
        check("instr", INSTR, m_instr);
        check("drdata", DRDATA, m_drdata);
        check("halt", 32'(HALT), 32'(m_halt));
        check("halt_code", HALT_CODE, m_code);
        check("con_valid", 32'(CON_VALID), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("con_data", 32'(CON_DATA), 32'(m_q[0]));
    endtask

    task automatic quiet();
        IREQ = 0; DREQ = 0; DRW = 0; LD_WE = 0;
    endtask

    task automatic dwrite(input logic [29:0] a, input logic [31:0] d);
        DREQ = 1; DRW = 1; DADDR = a; DWDATA = d;
        step();
        DREQ = 0; DRW = 0;
    endtask

    task automatic dread(input logic [29:0] a);
        DREQ = 1; DRW = 0; DADDR = a;
        step();
        DREQ = 0;
    endtask

    initial begin
        logic [31:0] old7;
        RST = 1; quiet(); IADDR = 30'd5; DADDR = '0; DWDATA = '0;
        LD_ADDR = '0; LD_DATA = '0; CON_READY = 0;
        m_instr = 0; m_drdata = 0; m_cnt = 0; m_halt = 0; m_code = 0; m_ovf = 0;

        // load the whole image while in reset; word 5 carries the known pattern
        IREQ = 1;
        for (int i = 0; i < (1 << AW); i++) begin
            LD_WE = 1; LD_ADDR = AW'(i);
            LD_DATA = (i == 5) ? 32'h1111_1111 : $urandom;
            step();
        end
        check("rst_instr", INSTR, 32'h0);
        check("rst_cycle_halt", 32'(HALT), 32'h0);
        quiet();
        RST = 0;

        IREQ = 1; IADDR = 30'd5; step(); IREQ = 0;
        check("fetch_w5", INSTR, 32'h1111_1111);

        // data write with a colliding fetch of the same word
        old7 = m_mem[7];
        IREQ = 1; IADDR = 30'd7;
        dwrite(30'd7, 32'hDEAD_BEEF);
        IREQ = 0;
        check("fetch_old_w7", INSTR, old7);
        dread(30'd7);
        check("read_w7", DRDATA, 32'hDEAD_BEEF);

        // cycle counter load and wrap
        dwrite(A_CYCLE, 32'd100);
        repeat (3) step();
        dread(A_CYCLE);
        check("cycle_103", DRDATA, 32'd103);
        dwrite(A_CYCLE, 32'hFFFF_FFFF);
        step();
        dread(A_CYCLE);
        check("cycle_wrap", DRDATA, 32'h0);

        // nine pushes into an eight-deep FIFO with the sink stalled
        CON_READY = 0;
        for (int k = 0; k < 9; k++) dwrite(A_CON, 32'h41 + k);
        dread(A_CON);
        check("con_ovf_full", DRDATA, 32'b110);
        CON_READY = 1;
        for (int k = 0; k < 8; k++) begin
            check("drain_byte", 32'(CON_DATA), 32'h41 + k);
            step();
        end
        check("drain_empty", 32'(CON_VALID), 32'h0);
        dread(A_CON);
        check("con_ovf_empty", DRDATA, 32'b101);

        // push and pop on the same edge while full
        RST = 1; step(); RST = 0;
        CON_READY = 0;
        for (int k = 0; k < 8; k++) dwrite(A_CON, 32'h30 + k);
        CON_READY = 1;
        dwrite(A_CON, 32'h99);
        CON_READY = 0;
        dread(A_CON);
        check("full_pushpop", DRDATA, 32'b010);
        CON_READY = 1;
        for (int k = 0; k < 8; k++) begin
            check("pushpop_byte", 32'(CON_DATA), (k < 7) ? 32'h31 + k : 32'h99);
            step();
        end
        CON_READY = 0;

        // HALT set, update, cleared by reset; RAM image survives
        dwrite(A_HALT, 32'h2A);
        check("halt_set", 32'(HALT), 32'h1);
        check("halt_code", HALT_CODE, 32'h2A);
        dwrite(A_HALT, 32'h55);
        check("halt_sticky", 32'(HALT), 32'h1);
        check("halt_code2", HALT_CODE, 32'h55);
        dread(A_HALT);
        check("halt_read", DRDATA, 32'h55);
        RST = 1; step();
        check("rst_halt", 32'(HALT), 32'h0);
        check("rst_halt_code", HALT_CODE, 32'h0);
        RST = 0;
        dread(30'd5);
        check("w5_survives", DRDATA, 32'h1111_1111);
        IREQ = 1; IADDR = 30'h2000_0005; step(); IREQ = 0;
        check("fetch_mmio", INSTR, 32'h0);

        // random traffic over a small address pool so collisions are frequent
        for (int i = 0; i < 3000; i++) begin
            logic mm;
            RST = ($urandom_range(0, 199) == 0);
            LD_WE = ($urandom_range(0, 15) == 0);
            LD_ADDR = AW'($urandom_range(0, 15));
            LD_DATA = $urandom;
            IREQ = 1'($urandom_range(0, 1));
            IADDR = {($urandom_range(0, 7) == 0), 17'($urandom), 12'($urandom_range(0, 15))};
            DREQ = 1'($urandom_range(0, 1));
            DRW = 1'($urandom_range(0, 1));
            mm = ($urandom_range(0, 2) == 0);
            DADDR = mm ? {1'b1, 25'($urandom), 4'($urandom_range(0, 5))}
                       : {1'b0, 17'($urandom), 12'($urandom_range(0, 15))};
            DWDATA = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            CON_READY = ($urandom_range(0, 3) < (((i / 150) % 2) ? 1 : 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
